// File: rtl/shifter_arbiter_if.sv
// Request/response bundle for shifter_arbiter.
//   req0_*/req1_* : valid/ready request ports, operand, shift amount, opcode
//   rsp_*         : registered response slot (valid/ready) with result and requester id
// Modports: master = requesters + consumer side, slave = the arbiter.
interface shifter_arbiter_if #(
  parameter int OPERAND_WIDTH  = 16,
  parameter int SHAMT_WIDTH    = 4,
  parameter int NUM_OPERATIONS = 2
);
  logic                      req0_valid;
  logic [OPERAND_WIDTH-1:0]  req0_in;
  logic [SHAMT_WIDTH-1:0]    req0_shamt;
  logic [NUM_OPERATIONS-1:0] req0_oper;
  logic                      req0_ready;
  logic                      req1_valid;
  logic [OPERAND_WIDTH-1:0]  req1_in;
  logic [SHAMT_WIDTH-1:0]    req1_shamt;
  logic [NUM_OPERATIONS-1:0] req1_oper;
  logic                      req1_ready;
  logic                      rsp_valid;
  logic [OPERAND_WIDTH-1:0]  rsp_out;
  logic                      rsp_id;
  logic                      rsp_ready;

  modport master (
    output req0_valid, req0_in, req0_shamt, req0_oper, input req0_ready,
    output req1_valid, req1_in, req1_shamt, req1_oper, input req1_ready,
    input  rsp_valid, rsp_out, rsp_id, output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_in, req0_shamt, req0_oper, output req0_ready,
    input  req1_valid, req1_in, req1_shamt, req1_oper, output req1_ready,
    output rsp_valid, rsp_out, rsp_id, input rsp_ready
  );
endinterface

// File: rtl/shifter_arbiter.sv
// Two-requester round-robin arbiter in front of one shared barrel shifter.
// The winner's operands drive the shifter combinationally; the result lands
// in a single registered response slot tagged with the winner's id.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : shifter_arbiter_if.slave (request ports + response slot)

// Combinational barrel shifter.
//   oper 00 rotate left, 01 shift left logical,
//        10 shift right arithmetic, 11 shift right logical
module shifter_arbiter_shf #(
  parameter int OPERAND_WIDTH  = 16,
  parameter int SHAMT_WIDTH    = 4,
  parameter int NUM_OPERATIONS = 2
) (
  input  logic [OPERAND_WIDTH-1:0]  data_i,
  input  logic [SHAMT_WIDTH-1:0]    shamt_i,
  input  logic [NUM_OPERATIONS-1:0] oper_i,
  output logic [OPERAND_WIDTH-1:0]  data_o
);
  localparam logic [NUM_OPERATIONS-1:0] OP_ROL = NUM_OPERATIONS'(0);
  localparam logic [NUM_OPERATIONS-1:0] OP_SLL = NUM_OPERATIONS'(1);
  localparam logic [NUM_OPERATIONS-1:0] OP_SRA = NUM_OPERATIONS'(2);

  // Rotate = upper half of the doubled operand shifted left.
  logic [2*OPERAND_WIDTH-1:0] dbl;
  assign dbl = {data_i, data_i} << shamt_i;

  always_comb begin
    data_o = data_i >> shamt_i;
    case (oper_i)
      OP_ROL:  data_o = dbl[2*OPERAND_WIDTH-1:OPERAND_WIDTH];
      OP_SLL:  data_o = data_i << shamt_i;
      OP_SRA:  data_o = OPERAND_WIDTH'($signed(data_i) >>> shamt_i);
      default: data_o = data_i >> shamt_i;
    endcase
  end
endmodule

module shifter_arbiter #(
  parameter int OPERAND_WIDTH  = 16,
  parameter int SHAMT_WIDTH    = 4,
  parameter int NUM_OPERATIONS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  shifter_arbiter_if.slave bus
);
  typedef struct packed {
    logic [OPERAND_WIDTH-1:0]  in;
    logic [SHAMT_WIDTH-1:0]    shamt;
    logic [NUM_OPERATIONS-1:0] oper;
  } req_t;

  req_t [1:0] req;
  logic [1:0] vld;
  req_t       win;

  assign req[0] = {bus.req0_in, bus.req0_shamt, bus.req0_oper};
  assign req[1] = {bus.req1_in, bus.req1_shamt, bus.req1_oper};
  assign vld    = {bus.req1_valid, bus.req0_valid};

  logic                     rsp_valid_q, rsp_valid_d;
  logic [OPERAND_WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic                     rsp_id_q, rsp_id_d;
  logic                     last_q, last_d;

  logic                     gnt_id;
  logic                     slot_free;
  logic                     accept;
  logic [OPERAND_WIDTH-1:0] shf_res;

  // Under contention the requester not served last wins; otherwise the lone
  // valid requester wins.
  always_comb begin
    gnt_id = vld[1];
    if (&vld) gnt_id = ~last_q;
  end

  assign slot_free = !rsp_valid_q || bus.rsp_ready;
  // rst_n gating keeps both readys low for the whole reset window.
  assign accept    = rst_n && slot_free && (|vld);

  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept &&  gnt_id;

  assign win = req[gnt_id];

  shifter_arbiter_shf #(
    .OPERAND_WIDTH (OPERAND_WIDTH),
    .SHAMT_WIDTH   (SHAMT_WIDTH),
    .NUM_OPERATIONS(NUM_OPERATIONS)
  ) u_shf (
    .data_i (win.in),
    .shamt_i(win.shamt),
    .oper_i (win.oper),
    .data_o (shf_res)
  );

  // Accept overrides drain, so a simultaneous drain+accept simply overwrites
  // the slot and keeps rsp_valid high.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_out_d   = rsp_out_q;
    rsp_id_d    = rsp_id_q;
    last_d      = last_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_out_d   = shf_res;
      rsp_id_d    = gnt_id;
      last_d      = gnt_id;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      rsp_id_q    <= 1'b0;
      last_q      <= 1'b1;  // requester 0 wins the first contention
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_id_q    <= rsp_id_d;
      last_q      <= last_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_id    = rsp_id_q;
endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
Shares one 16-bit barrel shifter between two requesters, for example the execute stage and a second shift client. Each requester has a valid/ready request port. A round-robin arbiter picks one request per cycle and drives the shared shifter combinationally. The result is captured in a single registered response slot, tagged with the winning requester's ID, and held until the consumer accepts it.

Parameters:
OPERAND_WIDTH, 16, width of operand and result
SHAMT_WIDTH, 4, width of shift amount
NUM_OPERATIONS, 2, width of operation code

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a request
req0_in  input  OPERAND_WIDTH  requester 0 operand
req0_shamt  input  SHAMT_WIDTH  requester 0 shift amount
req0_oper  input  NUM_OPERATIONS  requester 0 operation
req0_ready  output  1  requester 0 request accepted this cycle
req1_valid  input  1  requester 1 has a request
req1_in  input  OPERAND_WIDTH  requester 1 operand
req1_shamt  input  SHAMT_WIDTH  requester 1 shift amount
req1_oper  input  NUM_OPERATIONS  requester 1 operation
req1_ready  output  1  requester 1 request accepted this cycle
rsp_valid  output  1  response slot holds a result
rsp_out  output  OPERAND_WIDTH  shifted result
rsp_id  output  1  requester that produced rsp_out
rsp_ready  input  1  consumer takes the response this cycle

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Operation encoding: 00 rotate left, 01 shift left logical, 10 shift right arithmetic, 11 shift right logical.
  - The block forwards oper unchanged to the shifter.
- Reset values:
  - rsp_valid=0, rsp_out=0, rsp_id=0.
  - Internal last-grant pointer=1, so requester 0 wins the first contention.
  - req*_ready are combinational and are 0 while in reset.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Grant rules, evaluated combinationally each cycle:
  - Neither valid: no grant.
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to the last-grant pointer wins.
- Ready: reqK_ready = slot_free && (grant==K). At most one ready is high per cycle.
- Accept: an accept happens when reqK_valid && reqK_ready at the clock edge. On accept:
  - rsp_out <= shifter result of the winner's operands.
  - rsp_id <= K.
  - rsp_valid <= 1.
  - Last-grant pointer <= K.
- Drain: if rsp_valid && rsp_ready and there is no accept that cycle, rsp_valid <= 0. rsp_out and rsp_id hold their old values.
- Simultaneous drain and accept: the slot is overwritten with the new result and rsp_valid stays 1. This gives a throughput of one result per cycle.
- Latency: one cycle from accept edge to rsp_valid=1.
- Backpressure: while rsp_valid=1 and rsp_ready=0, both readys are 0.
  - rsp_out and rsp_id stay stable.
  - The pointer does not change.
- Request rule: once a requester asserts valid, it holds valid and all its fields stable until ready. The block does not rely on this rule for correctness.
- Pointer update: the pointer changes only on an accept. A lone requester accepted repeatedly keeps the pointer at its own ID.
- Reset mid-operation: any pending response is discarded, outputs return to reset values, and no partial state survives.
- Width rules: shamt is used modulo 2^SHAMT_WIDTH, with no saturation. The shifter is a combinational instance and there is no other arithmetic.

Test Plan:
- Reset then idle: rsp_valid=0, rsp_out=0, both readys 0 for 5 cycles.
- req0 alone, in=0x8001, shamt=1, oper=00 -> req0_ready=1. Next cycle rsp_valid=1, rsp_out=0x0003, rsp_id=0.
- Both valid at once:
  - req0: 0x00F0, shamt=4, oper=01.
  - req1: 0x8000, shamt=3, oper=10.
  - rsp_ready held 1.
  - Expected: req0 granted first, giving 0x0F00 with id 0. Next cycle req1 is granted, giving 0xF000 with id 1. The pointer alternates.
- Backpressure: rsp_ready=0 for 3 cycles with both requesters valid.
  - Expected: readys 0 and rsp_out stable for those 3 cycles.
  - When rsp_ready rises, the new grant goes to the requester not served last.
- Back-to-back streaming: req1 issues 0x8000, shamt=3, oper=11 every cycle with rsp_ready=1 -> one result per cycle, each 0x1000 with id 1, and no bubbles.
- Assert rst_n=0 while rsp_valid=1 -> rsp_valid clears immediately without waiting for a clock edge. After release, requester 0 wins the first contention.
